// File: rtl/piso_serializer.sv
// Parallel-in serial-out register with a load handshake and a valid/ready bit stream.
// Define PISO_PARITY_EN to append an even-parity bit after the N data bits.
module piso_serializer #(
    parameter int unsigned N         = 6,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] D,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_first,
    output logic         ser_last,
    output logic         busy
);

    localparam int unsigned CW = $clog2(N + 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           head;
    logic [N-1:0]   shifted;
    logic           last_data;

`ifdef PISO_PARITY_EN
    logic parity_q, parity_d;
`endif

    // Head bit is the next bit on the wire; the register always shifts toward it.
    assign head      = (MSB_FIRST != 0) ? shreg_q[N-1] : shreg_q[0];
    assign shifted   = (MSB_FIRST != 0) ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};
    assign last_data = (cnt_q == CW'(N - 1));
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        ser_first  = 1'b0;
        ser_last   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d   = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                load_ready = !rst;
                if (load_valid) begin
                    shreg_d = D;
                    cnt_d   = '0;
                    state_d = StShift;
`ifdef PISO_PARITY_EN
                    parity_d = ^D;
`endif
                end
            end
            StShift: begin
                ser_valid = 1'b1;
                ser_out   = head;
                ser_first = (cnt_q == '0);
`ifndef PISO_PARITY_EN
                ser_last  = last_data;
`endif
                if (ser_ready) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_data) begin
`ifdef PISO_PARITY_EN
                        state_d = StPar;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            StPar: begin
                ser_valid = 1'b1;
                ser_out   = parity_q;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus.
// Define PISO_PARITY_EN to check the parity bit as well.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [5:0] D;
    logic       ser_ready;

    logic m_load_ready, m_ser_out, m_ser_valid, m_ser_first, m_ser_last, m_busy;
    logic l_load_ready, l_ser_out, l_ser_valid, l_ser_first, l_ser_last, l_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    piso_serializer #(.N(6), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (m_load_ready),
        .D          (D),
        .ser_out    (m_ser_out),
        .ser_valid  (m_ser_valid),
        .ser_ready  (ser_ready),
        .ser_first  (m_ser_first),
        .ser_last   (m_ser_last),
        .busy       (m_busy)
    );

    piso_serializer #(.N(6), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (l_load_ready),
        .D          (D),
        .ser_out    (l_ser_out),
        .ser_valid  (l_ser_valid),
        .ser_ready  (ser_ready),
        .ser_first  (l_ser_first),
        .ser_last   (l_ser_last),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_m_busy"}, 32'(m_busy), 0);
        check({tag, "_m_valid"}, 32'(m_ser_valid), 0);
        check({tag, "_m_out"}, 32'(m_ser_out), 0);
        check({tag, "_m_ready"}, 32'(m_load_ready), 1);
        check({tag, "_l_busy"}, 32'(l_busy), 0);
        check({tag, "_l_valid"}, 32'(l_ser_valid), 0);
        check({tag, "_l_ready"}, 32'(l_load_ready), 1);
    endtask

    // Called at a negedge with both instances idle; returns one negedge after the load edge.
    task automatic load_word(input string tag, input logic [5:0] d);
        check({tag, "_m_load_ready"}, 32'(m_load_ready), 1);
        check({tag, "_l_load_ready"}, 32'(l_load_ready), 1);
        load_valid = 1'b1;
        D          = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // seq_* lists the bits in wire order, seq[5] first.
    task automatic check_bit(input string tag, input int i,
                             input logic [5:0] seq_m, input logic [5:0] seq_l);
        string t;
        logic  exp_last;
`ifdef PISO_PARITY_EN
        exp_last = 1'b0;
`else
        exp_last = (i == 5);
`endif
        t = $sformatf("%s_b%0d", tag, i);
        check({t, "_m_valid"}, 32'(m_ser_valid), 1);
        check({t, "_m_out"}, 32'(m_ser_out), 32'(seq_m[5-i]));
        check({t, "_m_first"}, 32'(m_ser_first), 32'(i == 0));
        check({t, "_m_last"}, 32'(m_ser_last), 32'(exp_last));
        check({t, "_l_valid"}, 32'(l_ser_valid), 1);
        check({t, "_l_out"}, 32'(l_ser_out), 32'(seq_l[5-i]));
        check({t, "_l_first"}, 32'(l_ser_first), 32'(i == 0));
        check({t, "_l_last"}, 32'(l_ser_last), 32'(exp_last));
    endtask

    task automatic expect_frame(input string tag, input logic [5:0] seq_m,
                                input logic [5:0] seq_l, input int stall_idx,
                                input int stall_n, input int pulse_idx, input logic par);
        for (int i = 0; i < 6; i++) begin
            if (i == pulse_idx) begin
                load_valid = 1'b1;
                D          = 6'b000111;
                check({tag, "_busy_m_load_ready"}, 32'(m_load_ready), 0);
                check({tag, "_busy_l_load_ready"}, 32'(l_load_ready), 0);
            end
            if (i == stall_idx) begin
                ser_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check_bit($sformatf("%s_stall%0d", tag, s), i, seq_m, seq_l);
                    @(negedge clk);
                    load_valid = 1'b0;
                end
                ser_ready = 1'b1;
            end
            check_bit(tag, i, seq_m, seq_l);
            @(negedge clk);
            load_valid = 1'b0;
        end
`ifdef PISO_PARITY_EN
        check({tag, "_par_m_valid"}, 32'(m_ser_valid), 1);
        check({tag, "_par_m_out"}, 32'(m_ser_out), 32'(par));
        check({tag, "_par_m_last"}, 32'(m_ser_last), 1);
        check({tag, "_par_m_first"}, 32'(m_ser_first), 0);
        check({tag, "_par_l_out"}, 32'(l_ser_out), 32'(par));
        check({tag, "_par_l_last"}, 32'(l_ser_last), 1);
        @(negedge clk);
`else
        if (par === 1'bx) $display("parity argument unused");
`endif
        check_idle({tag, "_end"});
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        D          = '0;
        ser_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_m_load_ready", 32'(m_load_ready), 0);
        check("rst_m_busy", 32'(m_busy), 0);
        check("rst_m_valid", 32'(m_ser_valid), 0);
        check("rst_m_out", 32'(m_ser_out), 0);
        check("rst_m_first", 32'(m_ser_first), 0);
        check("rst_m_last", 32'(m_ser_last), 0);
        check("rst_l_load_ready", 32'(l_load_ready), 0);
        rst = 1'b0;
        #1;
        check_idle("post_rst");
        @(negedge clk);

        // Basic frame; the LSB sequence of 101101 is its own reverse.
        load_word("basic", 6'b101101);
        expect_frame("basic", 6'b101101, 6'b101101, -1, 0, -1, 1'b0);

        load_word("order", 6'b110010);
        expect_frame("order", 6'b110010, 6'b010011, -1, 0, -1, 1'b1);

        load_word("bp", 6'b111000);
        expect_frame("bp", 6'b111000, 6'b000111, 2, 3, -1, 1'b1);

        load_word("lwb", 6'b101010);
        expect_frame("lwb", 6'b101010, 6'b010101, -1, 0, 2, 1'b1);
        load_word("lwb_next", 6'b110010);
        expect_frame("lwb_next", 6'b110010, 6'b010011, -1, 0, -1, 1'b1);

        // Reset after three bits of 110011 (palindrome: both orders send 1,1,0 first).
        load_word("rstmid", 6'b110011);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rstmid_b%0d_m_out", i), 32'(m_ser_out), (i < 2) ? 1 : 0);
            check($sformatf("rstmid_b%0d_l_out", i), 32'(l_ser_out), (i < 2) ? 1 : 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_m_valid", 32'(m_ser_valid), 0);
        check("rstmid_m_busy", 32'(m_busy), 0);
        check("rstmid_m_out", 32'(m_ser_out), 0);
        check("rstmid_m_load_ready", 32'(m_load_ready), 0);
        check("rstmid_l_valid", 32'(l_ser_valid), 0);
        rst = 1'b0;
        #1;
        check_idle("rstmid_release");
        @(negedge clk);
        load_word("after_rst", 6'b010101);
        expect_frame("after_rst", 6'b010101, 6'b101010, -1, 0, -1, 1'b1);

`ifdef PISO_PARITY_EN
        load_word("par1", 6'b101100);
        expect_frame("par1", 6'b101100, 6'b001101, -1, 0, -1, 1'b1);
        load_word("par0", 6'b100100);
        expect_frame("par0", 6'b100100, 6'b001001, 3, 2, -1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out register with a parallel load handshake on the input side and a valid/ready serial stream on the output side.
- Captures an N-bit word and shifts it out one bit per accepted transfer.
- Counterpart to the team's parallel N-bit registers, for driving serial links and deserializers.
- Sits between a word-wide producer and a 1-bit-wide consumer.

Parameters:
- N, 6, data word width in bits (N >= 2).
- MSB_FIRST, 1, 1 = transmit D[N-1] first; 0 = transmit D[0] first.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- load_valid  input  1  producer presents a word on D
- load_ready  output  1  serializer can accept a word
- D  input  N  parallel data word
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out holds a valid bit
- ser_ready  input  1  consumer accepts ser_out this cycle
- ser_first  output  1  current bit is the first bit of the frame
- ser_last  output  1  current bit is the last bit of the frame
- busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE, shift register 0, bit counter 0, ser_out 0, ser_valid 0, ser_first 0, ser_last 0, busy 0.
  - load_ready = (state == IDLE) && !rst, so it is 0 while rst is high.
- States: IDLE, SHIFT, PAR (PAR is present only with PARITY_EN).
- IDLE:
  - load_ready = 1.
  - On an edge with load_valid=1, D is captured into the shift register, the counter is set to 0, and the state moves to SHIFT.
- SHIFT:
  - ser_valid = 1.
  - ser_out = the current head bit: shreg[N-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0.
  - ser_first = 1 when counter == 0.
  - A transfer occurs on an edge with ser_valid && ser_ready. The register then shifts toward the head, fills with 0, and the counter increments.
  - Transfer of bit N-1 (counter == N-1):
    - Without PARITY_EN: go to IDLE.
    - With PARITY_EN: go to PAR.
  - ser_last = 1 when counter == N-1 and PARITY_EN is not defined.
- Backpressure: while ser_valid=1 and ser_ready=0, ser_out, ser_first, ser_last and the state hold stable for any number of cycles.
- Latency:
  - First bit is valid the cycle after the load edge.
  - With ser_ready held at 1, a frame occupies N cycles (N+1 with parity).
  - One IDLE cycle separates frames, so peak throughput is N bits per N+1 cycles.
- load_valid while busy: ignored, since load_ready=0. D is not sampled.
- ser_out, ser_first and ser_last are 0 whenever ser_valid=0.
- Counter width is $clog2(N+1). It never exceeds N-1 in SHIFT.
- Reset mid-frame:
  - Frame aborted with no further bits.
  - All outputs take their reset values on the next edge.
  - load_ready rises in the first cycle with rst=0.
- ser_ready is ignored in IDLE.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - A parity bit equal to the XOR of all N captured data bits (even parity) is computed at load and held.
  - After bit N-1 transfers, the state moves to PAR: ser_valid=1, ser_out=parity, ser_last=1, ser_first=0.
  - On transfer, the state returns to IDLE.
  - Backpressure rules apply to the parity bit exactly as to data bits.
- Not defined: there is no PAR state or parity logic, the frame is N bits, and ser_last marks data bit N-1.

Test Plan:
- Basic frame (N=6, MSB_FIRST=1, ser_ready=1): load D=6'b101101 → ser_out sequence 1,0,1,1,0,1 on 6 consecutive cycles starting 1 cycle after the load edge. ser_first on cycle 1 only, ser_last on cycle 6 only, then IDLE with load_ready=1.
- LSB first (MSB_FIRST=0): load D=6'b110010 → ser_out sequence 0,1,0,0,1,1.
- Backpressure: load D=6'b111000 and hold ser_ready=0 for 3 cycles on bit index 2 → ser_out stays 1 and ser_valid stays 1 for all 3 cycles. Full sequence 1,1,1,0,0,0 with no bit lost or duplicated.
- Load while busy: pulse load_valid with D=6'b000111 during the frame of 6'b101010 → ignored; transmitted bits are 1,0,1,0,1,0 only. Next load after IDLE is accepted normally.
- Reset mid-frame: assert rst after 3 bits of 6'b110011 → next cycle ser_valid=0, busy=0, ser_out=0. After rst drops, load_ready=1 and a new load of 6'b010101 transmits cleanly.
- PISO_PARITY_EN: load D=6'b101100 (three ones) → 6 data bits, then a 7th bit ser_out=1 with ser_last=1. Load 6'b100100 → parity bit 0.
